stack_mem_responder: RTL
========================

Name: stack_mem_responder

Overview:
- Memory-side responder for the datapath's two memory access channels: channel 1 carries PC/MSP traffic, channel 2 carries MSP/RSP traffic.
- Services read and write requests from both channels against one internal single-ported 16-bit word store.
- When both channels request together, it serializes them with fixed priority, channel 1 first.
- Each request completes with a one-cycle Ack pulse; read data is returned alongside the Ack.

Parameters:
- ADDR_W, 8, word-address bits decoded; the store holds 2**ADDR_W 16-bit words.
- WAIT_CYCLES, 0, extra wait states inserted before each access completes (0..15).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- Req1  input  1  channel 1 request; held high with fields stable until Ack1.
- Write1  input  1  channel 1: 1 = write, 0 = read.
- Addr1  input  16  channel 1 word address; only the low ADDR_W bits are used.
- WData1  input  16  channel 1 write data.
- Ack1  output  1  channel 1 completion, single-cycle pulse.
- RData1  output  16  channel 1 read data; valid while Ack1 is high and held afterwards.
- Req2, Write2, Addr2, WData2, Ack2, RData2: identical definitions for channel 2.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous and active-high:
  - state goes to IDLE; Ack1, Ack2 and Busy go to 0; RData1 and RData2 go to 0x0000.
  - pending flags, captured fields and the wait counter are cleared.
  - store contents are NOT cleared.
- Reset mid-operation aborts any in-flight request with no Ack; a write is applied only at its completing edge, so an aborted write is lost.
- States: IDLE, BUSY1, BUSY2.
- IDLE:
  - On each edge, capture each channel whose Req is high AND whose Ack is currently low. Captured fields: Write, low ADDR_W bits of Addr, WData. Each capture sets that channel's pending flag.
  - The Ack-low qualifier stops a Req still held in the Ack cycle from being re-captured.
  - Next state: BUSY1 if pending1 is set, else BUSY2 if pending2 is set, else stay in IDLE.
  - Load wait counter = WAIT_CYCLES.
- BUSY1 / BUSY2:
  - While the counter is nonzero, decrement it.
  - At the edge where the counter is 0, perform the access:
    - write: store[addr] <= wdata; RDataN is unchanged.
    - read: RDataN <= store[addr].
    - AckN <= 1 for exactly one cycle; clear pendingN.
  - Exit from BUSY1: go to BUSY2 with the counter reloaded if pending2 is set, else go to IDLE.
  - Exit from BUSY2: go to IDLE.
- No captures occur outside IDLE. A Req raised during BUSY waits, held, until the next IDLE sample.
- Latency: a Req seen in IDLE in cycle 0 gives Ack in cycle 2+WAIT_CYCLES.
  - If channel 2 is captured in the same cycle, Ack2 arrives in cycle 3+2*WAIT_CYCLES.
  - Back-to-back requests on one channel are serviced at best every 3+WAIT_CYCLES cycles.
- Simultaneous events, both captured in the same IDLE cycle:
  - Same-address write1 plus read2: read2 returns WData1.
  - Same-address read1 plus write2: read1 returns the old value.
  - Both writes to the same address: the final value is WData2.
- Address wrap: Addr bits above ADDR_W are ignored, so 0x0100 aliases 0x0000 when ADDR_W=8.
- Read of a never-written word returns the undefined store contents. The bench must preload or write the word first.
- A Req dropped before Ack is protocol misuse:
  - a captured request still completes.
  - the bench flags misuse with an assertion; the RTL does not.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, BUSY1=2'd1, BUSY2=2'd2).
  - DATA_W=16.
  - MAX_WAIT=15.
- One natural sub-module: stack_mem_array, a single-port synchronous word store (CLK, WE, Addr[ADDR_W-1:0], WData, RData) with registered read. The FSM shell owns the handshake, capture registers and wait counter.

Test Plan:
- Reset, then Req1 write Addr1=0x0010 WData1=0xBEEF (WAIT=0) -> Ack1 pulses in cycle 2 for one cycle. A later Req1 read of 0x0010 -> RData1=0xBEEF with Ack1.
- Same-cycle Req1 write 0x0020=0x1234 and Req2 read 0x0020 -> Ack1 in cycle 2, Ack2 in cycle 3, RData2=0x1234, Busy high in cycles 1-2.
- Same-cycle writes: Req1 0x0030=0xAAAA and Req2 0x0030=0x5555 -> a following read of 0x0030 returns 0x5555.
- WAIT_CYCLES=3, Req2 read 0x0130 after writing 0x0030=0x0F0F -> Ack2 in cycle 5, RData2=0x0F0F (address wrap).
- Req1 held high through its Ack cycle, then dropped -> exactly one Ack1 pulse, no second access.
- RST asserted mid-BUSY1 during a write of 0x0040=0x9999 -> Ack1 stays 0, outputs go to reset values immediately, a later read of 0x0040 returns the previous contents (preloaded 0x1111).

Source files
------------

// File: rtl/stack_mem_responder_pkg.sv
// Shared types and constants for the stack memory responder.
// State encoding is fixed because it is visible in waveforms and debug scripts.
package stack_mem_responder_pkg;

    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 15;
    localparam int WAIT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY1 = 2'd1,
        BUSY2 = 2'd2
    } state_t;

endpackage

// File: rtl/stack_mem_responder_array.sv
// Single-port synchronous word store with registered, read-first output.
// Contents are never reset; RData reflects the word addressed at the previous edge.
module stack_mem_array
    import stack_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              WE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (WE) begin
            mem[Addr] <= WData;
        end
        RData <= mem[Addr];
    end

endmodule

// File: rtl/stack_mem_responder.sv
// Two-channel memory responder: channel 1 has priority, Ack in cycle 2+WAIT_CYCLES after capture.
// Requests are held by the requester until Ack; nothing is captured while Busy.
module stack_mem_responder
    import stack_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req1,
    input  logic              Write1,
    input  logic [15:0]       Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData1,
    input  logic              Req2,
    input  logic              Write2,
    input  logic [15:0]       Addr2,
    input  logic [DATA_W-1:0] WData2,
    output logic              Ack2,
    output logic [DATA_W-1:0] RData2,
    output logic              Busy
);

    localparam logic [WAIT_W-1:0] WAIT_LD =
        (WAIT_CYCLES > MAX_WAIT) ? WAIT_W'(MAX_WAIT) : WAIT_W'(WAIT_CYCLES);

    state_t              state, stateNext;
    logic                pend1, pend2;
    logic                wr1Q, wr2Q;
    logic [ADDR_W-1:0]   addr1Q, addr2Q;
    logic [DATA_W-1:0]   wData1Q, wData2Q;
    logic [WAIT_W-1:0]   waitCnt;
    logic                ack1Q, ack2Q;
    logic                ackRead1, ackRead2;
    logic [DATA_W-1:0]   rdHold1, rdHold2;

    logic                cap1, cap2;
    logic                done;
    logic                memWe;
    logic [ADDR_W-1:0]   memAddr;
    logic [DATA_W-1:0]   memWData;
    logic [DATA_W-1:0]   memRData;
    logic                unusedAddrBits;

    assign unusedAddrBits = ^{Addr1, Addr2};

    // The Ack-low qualifier keeps a Req still held in its Ack cycle from re-entering.
    assign cap1 = Req1 && !ack1Q;
    assign cap2 = Req2 && !ack2Q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        done      = 1'b0;
        memWe     = 1'b0;
        memAddr   = addr1Q;
        memWData  = wData1Q;
        unique case (state)
            IDLE: begin
                if (pend1 || cap1) begin
                    stateNext = BUSY1;
                end else if (pend2 || cap2) begin
                    stateNext = BUSY2;
                end
            end
            BUSY1: begin
                if (waitCnt == '0) begin
                    done      = 1'b1;
                    memWe     = wr1Q;
                    stateNext = pend2 ? BUSY2 : IDLE;
                end
            end
            BUSY2: begin
                memAddr  = addr2Q;
                memWData = wData2Q;
                if (waitCnt == '0) begin
                    done      = 1'b1;
                    memWe     = wr2Q;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend1    <= 1'b0;
            pend2    <= 1'b0;
            wr1Q     <= 1'b0;
            wr2Q     <= 1'b0;
            addr1Q   <= '0;
            addr2Q   <= '0;
            wData1Q  <= '0;
            wData2Q  <= '0;
            waitCnt  <= '0;
            ack1Q    <= 1'b0;
            ack2Q    <= 1'b0;
            ackRead1 <= 1'b0;
            ackRead2 <= 1'b0;
            rdHold1  <= '0;
            rdHold2  <= '0;
        end else begin
            ack1Q <= 1'b0;
            ack2Q <= 1'b0;
            unique case (state)
                IDLE: begin
                    waitCnt <= WAIT_LD;
                    if (cap1) begin
                        pend1   <= 1'b1;
                        wr1Q    <= Write1;
                        addr1Q  <= Addr1[ADDR_W-1:0];
                        wData1Q <= WData1;
                    end
                    if (cap2) begin
                        pend2   <= 1'b1;
                        wr2Q    <= Write2;
                        addr2Q  <= Addr2[ADDR_W-1:0];
                        wData2Q <= WData2;
                    end
                end
                BUSY1: begin
                    if (!done) begin
                        waitCnt <= waitCnt - WAIT_W'(1);
                    end else begin
                        ack1Q    <= 1'b1;
                        ackRead1 <= !wr1Q;
                        pend1    <= 1'b0;
                        waitCnt  <= WAIT_LD;
                    end
                end
                BUSY2: begin
                    if (!done) begin
                        waitCnt <= waitCnt - WAIT_W'(1);
                    end else begin
                        ack2Q    <= 1'b1;
                        ackRead2 <= !wr2Q;
                        pend2    <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Read data arrives from the store during the Ack cycle; keep it afterwards.
            if (ack1Q && ackRead1) begin
                rdHold1 <= memRData;
            end
            if (ack2Q && ackRead2) begin
                rdHold2 <= memRData;
            end
        end
    end

    stack_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .CLK   (CLK),
        .WE    (memWe),
        .Addr  (memAddr),
        .WData (memWData),
        .RData (memRData)
    );

    assign Ack1   = ack1Q;
    assign Ack2   = ack2Q;
    assign RData1 = (ack1Q && ackRead1) ? memRData : rdHold1;
    assign RData2 = (ack2Q && ackRead2) ? memRData : rdHold2;
    assign Busy   = (state != IDLE);

endmodule
